hsi_rx_crc_check: RTL

HSI_RX_CRC_CHECK -- requirements
Module: hsi_rx_crc_check

---
 rtl/hsi_rx_crc_check.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hsi_rx_crc_check.sv
// Receive-side CRC-16/CCITT-FALSE checker: strips the two trailing CRC bytes,
// forwards the payload through a 2-byte delay line and issues one verdict per frame.
`timescale 1ns/1ps
module hsi_rx_crc_check #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [7:0]  out_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_type,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [1:0]  ERR_CRC   = 2'd0;
  localparam logic [1:0]  ERR_SHORT = 2'd1;
  localparam logic [1:0]  ERR_LONG  = 2'd2;
  localparam logic [1:0]  ERR_ABORT = 2'd3;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] crc_r, cnt_r;
  logic [7:0]  buf0_r, buf1_r;
  logic        sof_s, take_s, over_s;
  logic [15:0] crc_next_s;
  logic        out_valid_s, out_sof_s, out_eof_s, done_s, ok_s;
  logic [1:0]  err_s;

  // A sof byte reloads the CRC, so it always folds onto 0xFFFF regardless of state.
  assign sof_s      = in_valid & in_sof;
  assign take_s     = sof_s | (in_valid & (state_r == RECV));
  assign over_s     = in_valid & ~in_sof & (state_r == RECV) & (cnt_r >= MAX_LEN_W);
  assign crc_next_s = crc16_byte(sof_s ? 16'hFFFF : crc_r, in_data);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DISCARD: begin
        if (sof_s)                                         state_s = in_eof ? IDLE : RECV;
        else if (state_r == DISCARD && in_valid && in_eof) state_s = IDLE;
        else                                               state_s = state_r;
      end
      RECV: begin
        if (sof_s)                 state_s = in_eof ? IDLE : RECV;
        else if (over_s)           state_s = in_eof ? IDLE : DISCARD;
        else if (in_valid && in_eof) state_s = IDLE;
        else                       state_s = RECV;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode; forwarding starts once two bytes sit in the delay line
  always_comb begin
    out_valid_s = 1'b0;
    out_sof_s   = 1'b0;
    out_eof_s   = 1'b0;
    done_s      = 1'b0;
    ok_s        = 1'b0;
    err_s       = ERR_CRC;
    case (state_r)
      IDLE, DISCARD: begin
        if (sof_s && in_eof) begin
          done_s = 1'b1;
          err_s  = ERR_SHORT;
        end else begin
          done_s = 1'b0;
        end
      end
      RECV: begin
        if (sof_s) begin
          done_s = 1'b1;
          err_s  = ERR_ABORT;
        end else if (over_s) begin
          done_s = 1'b1;
          err_s  = ERR_LONG;
        end else if (in_valid && in_eof) begin
          done_s = 1'b1;
          if (cnt_r < 16'd2) begin
            err_s = ERR_SHORT;
          end else begin
            out_valid_s = 1'b1;
            out_eof_s   = 1'b1;
            out_sof_s   = (cnt_r == 16'd2);
            ok_s        = (crc_next_s == 16'h0000);
            err_s       = ERR_CRC;
          end
        end else if (in_valid && cnt_r >= 16'd2) begin
          out_valid_s = 1'b1;
          out_sof_s   = (cnt_r == 16'd2);
        end else begin
          out_valid_s = 1'b0;
        end
      end
      default: done_s = 1'b0;
    endcase
  end

  // CRC, saturating byte counter and the 2-byte delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r  <= 16'hFFFF;
      cnt_r  <= 16'd0;
      buf0_r <= 8'h00;
      buf1_r <= 8'h00;
    end else if (take_s) begin
      crc_r <= crc_next_s;
      if (sof_s) begin
        cnt_r  <= 16'd1;
        buf0_r <= 8'h00;
        buf1_r <= in_data;
      end else begin
        cnt_r  <= (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
        buf0_r <= buf1_r;
        buf1_r <= in_data;
      end
    end
  end

  // Registered outputs and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_type   <= 2'd0;
      err_cnt    <= 16'd0;
    end else begin
      out_valid  <= out_valid_s;
      out_sof    <= out_sof_s;
      out_eof    <= out_eof_s;
      out_data   <= out_valid_s ? buf0_r : 8'h00;
      frame_done <= done_s;
      frame_ok   <= ok_s;
      err_type   <= (done_s && !ok_s) ? err_s : 2'd0;
      if (done_s && !ok_s && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
